// File: rtl/imp_cycle_sched.sv
// Cycle scheduler for the pulse-timing unit.
// Holds a double-buffered table of segment descriptors (Pni, Pii, Pnp, Pip, QIT).
// From each cycle start it walks calibration, noise and segment modes. For every
// pulse it hands the timing unit one absolute four-timestamp event, then waits for
// the window end (obm_done) before building the next one.
//
// Handshake: ev_valid rises in ISSUE and stays high, with ev_kind/ev_t* held
// constant, until a cycle where ev_valid & ev_ready are both high. That cycle is
// the single transfer; ev_valid is low from the next cycle on.
module imp_cycle_sched #(
   parameter int N_SEG = 3,
   parameter int TW    = 32,
   parameter int QW    = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_we,
   input  logic [4:0]    cfg_addr,
   input  logic [31:0]   cfg_data,
   input  logic [1:0]    n_seg,
   input  logic          dop_en,
   input  logic [15:0]   dds_delay,
   input  logic [TW-1:0] dt_kal,
   input  logic [TW-1:0] dt_pom,
   input  logic [TW-1:0] time_now,
   input  logic          cycle_start,
   input  logic          obm_done,
   output logic          ev_valid,
   input  logic          ev_ready,
   output logic [1:0]    ev_kind,
   output logic [TW-1:0] ev_tni,
   output logic [TW-1:0] ev_tki,
   output logic [TW-1:0] ev_tnp,
   output logic [TW-1:0] ev_tkp,
   output logic [TW-1:0] tnc_next,
   output logic          tnc_valid,
   output logic          busy,
   output logic          err_overrun,
   output logic [2:0]    dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LATCH    = 3'd1,
      S_CALC     = 3'd2,
      S_ISSUE    = 3'd3,
      S_WAIT_OBM = 3'd4,
      S_DONE     = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      M_CAL   = 2'd0,
      M_NOISE = 2'd1,
      M_SEG   = 2'd2
   } mode_t;

   localparam logic [1:0]    LAST_SEG = 2'(N_SEG - 1);
   localparam logic [TW-1:0] TNC_GAP  = TW'(8);

   state_t state, state_nx;
   mode_t  mode;

   // Descriptor banks: index 0 Pni, 1 Pii, 2 Pnp, 3 Pip
   logic [TW-1:0] shd_tim [N_SEG][4];
   logic [QW-1:0] shd_qit [N_SEG];
   logic [TW-1:0] act_tim [N_SEG][4];
   logic [QW-1:0] act_qit [N_SEG];

   logic [TW-1:0] base;
   logic [1:0]    seg;
   logic [1:0]    n_lim;
   logic [QW-1:0] cnt;
   logic          seg_issued;

   // Current-segment view and next-segment search results
   logic [TW-1:0] cur_tim [4];
   logic [QW-1:0] cur_qit;
   logic [2:0]    srch_start;
   logic          srch_found;
   logic [1:0]    srch_idx;
   logic [QW-1:0] srch_qit;

   // Timestamp arithmetic, all modulo 2^TW
   logic [TW-1:0] dds_ext;
   logic [TW-1:0] seg_tni, seg_tki, seg_tnp, seg_tkp;
   logic [TW-1:0] aux_tnp, aux_tkp;

   // Host writes land in the shadow bank at any time
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < N_SEG; k++) begin
            shd_qit[k] <= '0;
            for (int f = 0; f < 4; f++) shd_tim[k][f] <= '0;
         end
      end else if (cfg_we) begin
         for (int k = 0; k < N_SEG; k++) begin
            if (!cfg_addr[4] && cfg_addr[3:2] == k[1:0]) begin
               for (int f = 0; f < 4; f++) begin
                  if (cfg_addr[1:0] == f[1:0]) shd_tim[k][f] <= TW'(cfg_data);
               end
            end
            if (cfg_addr[4] && cfg_addr[3:2] == 2'b00 && cfg_addr[1:0] == k[1:0]) begin
               shd_qit[k] <= QW'(cfg_data);
            end
         end
      end
   end

   // Active bank is snapshotted only when a cycle is accepted from IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < N_SEG; k++) begin
            act_qit[k] <= '0;
            for (int f = 0; f < 4; f++) act_tim[k][f] <= '0;
         end
      end else if (state == S_IDLE && cycle_start) begin
         act_tim <= shd_tim;
         act_qit <= shd_qit;
      end
   end

   // Mux out the descriptor of the segment currently being served
   always_comb begin
      cur_qit = '0;
      for (int f = 0; f < 4; f++) cur_tim[f] = '0;
      for (int k = 0; k < N_SEG; k++) begin
         if (seg == k[1:0]) begin
            cur_qit = act_qit[k];
            for (int f = 0; f < 4; f++) cur_tim[f] = act_tim[k][f];
         end
      end
   end

   // Lowest non-empty segment in [srch_start, n_lim]; from 0 after noise, else after seg
   always_comb begin
      srch_start = (mode == M_SEG) ? ({1'b0, seg} + 3'd1) : 3'd0;
      srch_found = 1'b0;
      srch_idx   = '0;
      srch_qit   = '0;
      for (int k = N_SEG - 1; k >= 0; k--) begin
         if (k[2:0] >= srch_start && k[2:0] <= {1'b0, n_lim} && act_qit[k] != '0) begin
            srch_found = 1'b1;
            srch_idx   = k[1:0];
            srch_qit   = act_qit[k];
         end
      end
   end

   // Event timestamps for the current mode, relative to base
   always_comb begin
      dds_ext = TW'(dds_delay);
      seg_tni = base + cur_tim[0];
      seg_tki = seg_tni + cur_tim[1];
      seg_tnp = seg_tki + cur_tim[2];
      seg_tkp = seg_tnp + cur_tim[3];
      aux_tnp = base + dds_ext;
      aux_tkp = aux_tnp + ((mode == M_CAL) ? dt_kal : dt_pom);
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // FSM next state and state-decoded outputs
   always_comb begin
      state_nx  = state;
      ev_valid  = 1'b0;
      busy      = (state != S_IDLE);
      dbg_state = state;
      case (state)
         S_IDLE: begin
            if (cycle_start) state_nx = S_LATCH;
         end
         S_LATCH: begin
            // One clock per empty segment skipped at the start of the cycle
            if (mode != M_SEG || cur_qit != '0) state_nx = S_CALC;
            else if (seg >= n_lim)              state_nx = S_DONE;
         end
         S_CALC: begin
            state_nx = S_ISSUE;
         end
         S_ISSUE: begin
            ev_valid = 1'b1;
            if (ev_ready) state_nx = S_WAIT_OBM;
         end
         S_WAIT_OBM: begin
            if (obm_done) begin
               case (mode)
                  M_CAL:   state_nx = S_CALC;
                  M_NOISE: state_nx = srch_found ? S_CALC : S_DONE;
                  default: begin
                     if (cnt > QW'(1) || srch_found) state_nx = S_CALC;
                     else                            state_nx = S_DONE;
                  end
               endcase
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Sequencing registers, event outputs, next-cycle strobe and overrun flag
   always_ff @(posedge clk) begin
      if (rst) begin
         mode        <= M_SEG;
         base        <= '0;
         seg         <= '0;
         n_lim       <= '0;
         cnt         <= '0;
         seg_issued  <= 1'b0;
         ev_kind     <= '0;
         ev_tni      <= '0;
         ev_tki      <= '0;
         ev_tnp      <= '0;
         ev_tkp      <= '0;
         tnc_next    <= '0;
         tnc_valid   <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         tnc_valid <= 1'b0;
         if (cycle_start && state != S_IDLE) err_overrun <= 1'b1;

         case (state)
            S_IDLE: begin
               if (cycle_start) begin
                  base       <= time_now;
                  n_lim      <= (n_seg > LAST_SEG) ? LAST_SEG : n_seg;
                  mode       <= dop_en ? M_CAL : M_SEG;
                  seg        <= '0;
                  cnt        <= shd_qit[0];
                  seg_issued <= 1'b0;
               end
            end
            S_LATCH: begin
               if (mode == M_SEG) begin
                  if (cur_qit != '0)    cnt <= cur_qit;
                  else if (seg < n_lim) seg <= seg + 2'd1;
               end
            end
            S_CALC: begin
               ev_kind <= mode;
               if (mode == M_SEG) begin
                  ev_tni <= seg_tni;
                  ev_tki <= seg_tki;
                  ev_tnp <= seg_tnp;
                  ev_tkp <= seg_tkp;
               end else begin
                  ev_tni <= '0;
                  ev_tki <= '0;
                  ev_tnp <= aux_tnp;
                  ev_tkp <= aux_tkp;
               end
            end
            S_ISSUE: begin
               if (ev_ready && mode == M_SEG) seg_issued <= 1'b1;
            end
            S_WAIT_OBM: begin
               if (obm_done) begin
                  base <= time_now;
                  case (mode)
                     M_CAL: mode <= M_NOISE;
                     M_NOISE: begin
                        if (srch_found) begin
                           mode <= M_SEG;
                           seg  <= srch_idx;
                           cnt  <= srch_qit;
                        end
                     end
                     default: begin
                        if (cnt > QW'(1)) begin
                           cnt <= cnt - QW'(1);
                        end else if (srch_found) begin
                           seg <= srch_idx;
                           cnt <= srch_qit;
                        end else begin
                           cnt <= '0;
                        end
                     end
                  endcase
               end
            end
            default: ;
         endcase

         // The last accepted event is still held on ev_tkp when DONE is entered
         if (state_nx == S_DONE && state != S_DONE && seg_issued) begin
            tnc_valid <= 1'b1;
            tnc_next  <= ev_tkp + TNC_GAP;
         end
      end
   end

endmodule

// File: tb/tb_imp_cycle_sched.sv
// Bench for imp_cycle_sched: directed cycles with hand-computed events.
// Drivers push expected events / next-cycle times; a monitor pops and compares.
module tb_imp_cycle_sched;

   localparam int TW = 32;

   // Clock and reset
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          cfg_we;
   logic [4:0]    cfg_addr;
   logic [31:0]   cfg_data;
   logic [1:0]    n_seg;
   logic          dop_en;
   logic [15:0]   dds_delay;
   logic [TW-1:0] dt_kal, dt_pom, time_now;
   logic          cycle_start, obm_done;
   logic          ev_valid, ev_ready;
   logic [1:0]    ev_kind;
   logic [TW-1:0] ev_tni, ev_tki, ev_tnp, ev_tkp, tnc_next;
   logic          tnc_valid, busy, err_overrun;
   logic [2:0]    dbg_state;

   imp_cycle_sched #(.N_SEG(3), .TW(TW), .QW(16)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .n_seg(n_seg), .dop_en(dop_en), .dds_delay(dds_delay), .dt_kal(dt_kal),
      .dt_pom(dt_pom), .time_now(time_now), .cycle_start(cycle_start),
      .obm_done(obm_done), .ev_valid(ev_valid), .ev_ready(ev_ready),
      .ev_kind(ev_kind), .ev_tni(ev_tni), .ev_tki(ev_tki), .ev_tnp(ev_tnp),
      .ev_tkp(ev_tkp), .tnc_next(tnc_next), .tnc_valid(tnc_valid), .busy(busy),
      .err_overrun(err_overrun), .dbg_state(dbg_state)
   );

   // Scoreboard
   logic [2+4*TW-1:0] exp_q[$];
   logic [TW-1:0]     tnc_q[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic push_ev(input logic [1:0] k, input logic [TW-1:0] a, input logic [TW-1:0] b,
                          input logic [TW-1:0] c, input logic [TW-1:0] d);
      exp_q.push_back({k, a, b, c, d});
   endtask

   // Monitor: every transfer and every next-cycle strobe is matched against the queues
   always @(negedge clk) begin
      if (!rst) begin
         if (ev_valid && ev_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL ev_unexpected got=%0h exp=none", {ev_kind, ev_tni, ev_tki, ev_tnp, ev_tkp});
            end else begin
               automatic logic [2+4*TW-1:0] e = exp_q.pop_front();
               if ({ev_kind, ev_tni, ev_tki, ev_tnp, ev_tkp} !== e) begin
                  errors++;
                  $display("FAIL ev_event got=%0h exp=%0h", {ev_kind, ev_tni, ev_tki, ev_tnp, ev_tkp}, e);
               end
            end
         end
         if (tnc_valid) begin
            checks++;
            if (tnc_q.size() == 0) begin
               errors++;
               $display("FAIL tnc_unexpected got=%0h exp=none", tnc_next);
            end else begin
               automatic logic [TW-1:0] t = tnc_q.pop_front();
               if (tnc_next !== t) begin
                  errors++;
                  $display("FAIL tnc_next got=%0h exp=%0h", tnc_next, t);
               end
            end
         end
      end
   end

   // Driver tasks
   task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   task automatic start(input logic [TW-1:0] tn);
      @(posedge clk); #1;
      time_now = tn; cycle_start = 1'b1;
      @(posedge clk); #1;
      cycle_start = 1'b0;
   endtask

   task automatic obm(input logic [TW-1:0] tn);
      @(posedge clk); #1;
      time_now = tn; obm_done = 1'b1;
      @(posedge clk); #1;
      obm_done = 1'b0;
   endtask

   // Clocks from the start-sampling edge until ev_valid is seen
   task automatic check_latency(input int exp_lat);
      int  n = 1;
      bit  found = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ev_valid) begin found = 1; break; end
         @(posedge clk);
         n++;
      end
      if (!found) n = -1;
      chk("latency", 64'(n), 64'(exp_lat));
   endtask

   task automatic wait_xfer();
      bit ok = 0;
      for (int i = 0; i < 50; i++) begin
         if (ev_valid && ev_ready) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL xfer_timeout got=none exp=transfer");
      end
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!busy) begin ok = 1; break; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL idle_timeout got=busy exp=idle");
      end
   endtask

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; n_seg = 2'd0;
      dop_en = 1'b0; dds_delay = '0; dt_kal = '0; dt_pom = '0; time_now = '0;
      cycle_start = 1'b0; obm_done = 1'b0; ev_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_ev_valid", 64'(ev_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_tnc_valid", 64'(tnc_valid), 64'd0);
      chk("rst_overrun", 64'(err_overrun), 64'd0);
      chk("rst_ev_tkp", 64'(ev_tkp), 64'd0);
      chk("rst_tnc_next", 64'(tnc_next), 64'd0);

      // Basic segment cycle: two pulses then next-cycle strobe
      cfg_write(5'd0, 32'd10); cfg_write(5'd1, 32'd20);
      cfg_write(5'd2, 32'd5);  cfg_write(5'd3, 32'd30);
      cfg_write(5'd16, 32'd2);
      push_ev(2'd2, 110, 130, 135, 165);
      push_ev(2'd2, 210, 230, 235, 265);
      tnc_q.push_back(273);
      start(100); check_latency(3);
      wait_xfer(); obm(200);
      wait_xfer(); obm(300);
      wait_idle();

      // Calibration + noise prepended
      dop_en = 1'b1; dds_delay = 16'd4; dt_kal = 50; dt_pom = 70;
      cfg_write(5'd16, 32'd1);
      push_ev(2'd0, 0, 0, 4, 54);
      push_ev(2'd1, 0, 0, 64, 134);
      push_ev(2'd2, 210, 230, 235, 265);
      tnc_q.push_back(273);
      start(0); check_latency(3);
      wait_xfer(); obm(60);
      wait_xfer(); obm(200);
      wait_xfer(); obm(300);
      wait_idle();
      dop_en = 1'b0;

      // Empty middle segment skipped: 3 from seg0, 1 from seg2
      n_seg = 2'd2;
      cfg_write(5'd16, 32'd3); cfg_write(5'd17, 32'd0); cfg_write(5'd18, 32'd1);
      cfg_write(5'd8, 32'd1); cfg_write(5'd9, 32'd2);
      cfg_write(5'd10, 32'd3); cfg_write(5'd11, 32'd4);
      push_ev(2'd2, 1010, 1030, 1035, 1065);
      push_ev(2'd2, 2010, 2030, 2035, 2065);
      push_ev(2'd2, 3010, 3030, 3035, 3065);
      push_ev(2'd2, 4001, 4003, 4006, 4010);
      tnc_q.push_back(4018);
      start(1000); check_latency(3);
      wait_xfer(); obm(2000);
      wait_xfer(); obm(3000);
      wait_xfer(); obm(4000);
      wait_xfer(); obm(5000);
      wait_idle();

      // Empty first segment costs one extra clock before the first event
      n_seg = 2'd1;
      cfg_write(5'd16, 32'd0); cfg_write(5'd17, 32'd1);
      cfg_write(5'd4, 32'd100); cfg_write(5'd7, 32'd7);
      push_ev(2'd2, 600, 600, 600, 607);
      tnc_q.push_back(615);
      start(500); check_latency(4);
      wait_xfer(); obm(700);
      wait_idle();

      // Back-pressure, shadow write and overrun during a cycle
      n_seg = 2'd0;
      cfg_write(5'd16, 32'd1);
      ev_ready = 1'b0;
      push_ev(2'd2, 110, 130, 135, 165);
      tnc_q.push_back(173);
      start(100); check_latency(3);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_valid", 64'(ev_valid), 64'd1);
         chk("stall_tni", 64'(ev_tni), 64'd110);
         chk("stall_tkp", 64'(ev_tkp), 64'd165);
      end
      cfg_write(5'd0, 32'd40);
      start(100);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_valid", 64'(ev_valid), 64'd1);
         chk("stall_tnp", 64'(ev_tnp), 64'd135);
      end
      chk("overrun_set", 64'(err_overrun), 64'd1);
      @(posedge clk); #1 ev_ready = 1'b1;
      wait_xfer(); obm(150);
      wait_idle();
      push_ev(2'd2, 340, 360, 365, 395);
      tnc_q.push_back(403);
      start(300); check_latency(3);
      wait_xfer(); obm(400);
      wait_idle();
      chk("overrun_sticky", 64'(err_overrun), 64'd1);

      // Timestamp wrap, then reset while waiting for the window end
      cfg_write(5'd0, 32'd32); cfg_write(5'd1, 32'd0);
      cfg_write(5'd2, 32'd0);  cfg_write(5'd3, 32'd0);
      push_ev(2'd2, 32'h10, 32'h10, 32'h10, 32'h10);
      start(32'hFFFF_FFF0); check_latency(3);
      wait_xfer();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_valid", 64'(ev_valid), 64'd0);
      chk("rst_mid_tnc", 64'(tnc_valid), 64'd0);
      chk("rst_mid_overrun", 64'(err_overrun), 64'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("post_rst_busy", 64'(busy), 64'd0);

      chk("ev_queue_empty", 64'(exp_q.size()), 64'd0);
      chk("tnc_queue_empty", 64'(tnc_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/imp_cycle_sched.md
Name: imp_cycle_sched

Overview:
Cycle scheduler for the pulse-timing unit (TNI/TKI/TNP/TKP/TOBM comparators against the 1 us time counter). It holds a host-written, double-buffered table of up to N_SEG segment descriptors (Pni, Pii, Pnp, Pip, QIT). Starting at each cycle start, it walks calibration, noise and segment modes. For each pulse, it hands the timing unit an absolute 4-timestamp event over a valid/ready handshake, then waits for the window-end (TOBM) before issuing the next event.

Parameters:
N_SEG, 3, number of segment descriptors (1..4)
TW, 32, timestamp width in 1 us ticks
QW, 16, per-segment pulse count width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cfg_we  in  1  host write strobe, shadow bank
cfg_addr  in  5  0..15: segment k=addr[3:2], field=addr[1:0] (0 Pni, 1 Pii, 2 Pnp, 3 Pip); 16..19: QIT of segment addr-16
cfg_data  in  32  write data (QIT uses [QW-1:0])
n_seg  in  2  active segments minus 1, sampled at cycle_start
dop_en  in  1  prepend calibration + noise events, sampled at cycle_start
dds_delay  in  16  DDS delay, zero-extended to TW
dt_kal  in  TW  calibration window length
dt_pom  in  TW  noise window length
time_now  in  TW  current time_from_start
cycle_start  in  1  single-cycle pulse: start of cycle (TNC edge)
obm_done  in  1  single-cycle pulse: current window ended (TOBM edge)
ev_valid  out  1  event available
ev_ready  in  1  timing unit accepts event
ev_kind  out  2  0 calibration, 1 noise, 2 segment
ev_tni, ev_tki, ev_tnp, ev_tkp  out  TW each  absolute timestamps; 0 = edge disabled
tnc_next  out  TW  next cycle start time
tnc_valid  out  1  1-cycle strobe with tnc_next
busy  out  1  FSM not IDLE
err_overrun  out  1  sticky: cycle_start seen while busy

Behaviour:
- Reset: FSM=IDLE. All outputs 0. Shadow and active banks cleared.
- Shadow bank is written on every cfg_we, any state. Active bank = copy of shadow, taken in the IDLE->LATCH cycle only. Writes during a cycle never affect it.
- FSM states: IDLE, LATCH, CALC, ISSUE, WAIT_OBM, DONE.
- IDLE + cycle_start -> LATCH:
  - base <= time_now, copy bank.
  - mode <= dop_en ? CAL : SEG with seg=0, cnt=QIT[0].
- LATCH -> CALC: find the first segment with QIT!=0 at or after seg. If none and mode=SEG -> DONE.
- CALC (1 cycle) computes from base, all sums mod 2^TW:
  - CAL: tni=tki=0, tnp=base+dds_delay, tkp=tnp+dt_kal.
  - NOISE: same as CAL with dt_pom in place of dt_kal.
  - SEG: tni=base+Pni, tki=tni+Pii, tnp=tki+Pnp, tkp=tnp+Pip.
- ISSUE: ev_valid=1; all ev_* held stable until ev_valid&ev_ready. On transfer -> WAIT_OBM, ev_valid=0 next cycle.
- cycle_start to first ev_valid: exactly 3 clocks with no skipped segments; +1 clock per skipped segment.
- WAIT_OBM + obm_done: base <= time_now, then advance:
  - CAL -> NOISE.
  - NOISE -> SEG 0.
  - SEG: cnt-1. At 0, go to next segment with QIT!=0. Past n_seg -> DONE, else CALC.
- If the last accepted event was SEG: on entry to DONE, tnc_next = last tkp + 8 and tnc_valid pulses 1 cycle. No strobe if no SEG event was issued. DONE -> IDLE next cycle.
- cycle_start while busy: ignored, err_overrun <= 1 (sticky until rst).
- obm_done outside WAIT_OBM is ignored. cycle_start and obm_done in the same cycle during WAIT_OBM: obm_done is served, overrun is flagged.
- rst mid-cycle: return to IDLE in 1 clock, ev_valid drops at once, no tnc_valid.

Test Plan:
- dop_en=0, n_seg=0, seg0 Pni=10 Pii=20 Pnp=5 Pip=30 QIT=2, time_now=100 at start, ev_ready=1 -> ev_valid 3 clocks later with tni=110, tki=130, tnp=135, tkp=165, kind=2. After obm_done at time_now=200: second event tni=210. After the next obm_done: tnc_valid with tnc_next=273.
- dop_en=1, dds_delay=4, dt_kal=50, dt_pom=70, base=0 -> calibration event tni=0, tnp=4, tkp=54, kind=0. After obm_done at time_now=60: noise event tnp=64, tkp=134, kind=1. Then segment events.
- n_seg=2, QIT={3,0,1} -> seg1 skipped; exactly 4 segment events issued (3 from seg0, 1 from seg2).
- ev_ready held low 10 clocks -> ev_valid and all timestamps stable for 10 clocks; single transfer.
- cfg_we changes Pni during a cycle -> current cycle unchanged; next cycle uses the new value. cycle_start while busy -> err_overrun=1, sequence unaffected.
- base=32'hFFFFFFF0, Pni=32 -> tni=32'h10 (wrap). rst asserted in WAIT_OBM -> busy=0 and ev_valid=0 next clock, no tnc_valid.
